arbitro_vc_pcie: RTL
====================

Name: arbitro_vc_pcie

Overview:
- Round-robin scheduler for the four virtual-channel (VC) FIFOs in the PCIE datapath.
- Pops at most one source VC FIFO per cycle and drives the shared 12-bit output bus. Pushes the word into the matching destination FIFO (source VC i feeds destination i).
- Applies per-destination back-pressure using the programmable low/high thresholds (umbral_L/umbral_H), with hysteresis.
- Owns the datapath control FSM: RESET, INIT, IDLE, ACTIVE, ERROR.

Parameters:
- TAMANO_DATOS, 12, data word width.
- UMBRALES_L_H, 8, width of the threshold registers and of each destination occupancy count.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- init  input  1  configuration request; thresholds are captured while high.
- umbral_L_in  input  UMBRALES_L_H  low threshold for resuming a destination.
- umbral_H_in  input  UMBRALES_L_H  high threshold for pausing a destination.
- vc_empty  input  4  empty flags of the source VC FIFOs.
- vc_data  input  4*TAMANO_DATOS  first-word-fall-through heads; VC i occupies bits [i*TAMANO_DATOS +: TAMANO_DATOS].
- dst_count  input  4*UMBRALES_L_H  occupancy of destination FIFO i.
- fifo_error  input  4  overflow/underflow flags from the FIFOs.
- vc_pop  output  4  one-hot pop to the source VC FIFOs (combinational from registered state).
- dst_push  output  4  one-hot push to the destination FIFOs (registered).
- data_out  output  TAMANO_DATOS  registered shared data bus.
- umbral_L, umbral_H  output  UMBRALES_L_H  active threshold registers.
- estado  output  3  FSM state.
- idle  output  1  high in IDLE.
- error_out  output  1  high in ERROR.

Behaviour:
- Reset (any cycle, including mid-transfer):
  - estado=RESET(000); vc_pop, dst_push, data_out, idle and error_out all 0.
  - umbral_L=1, umbral_H=6.
  - pause[3:0]=0; round-robin pointer last=3, so VC0 has first priority.
- State encoding: RESET=000, INIT=001, IDLE=010, ACTIVE=011, ERROR=100.
- FSM transitions:
  - RESET: -> INIT when init=1, else -> IDLE.
  - INIT: latch umbral_*_in every cycle while init=1. When init falls: if umbral_L<umbral_H -> IDLE, else -> ERROR.
  - IDLE: -> ACTIVE when any vc_empty bit is 0.
  - ACTIVE: -> IDLE when all vc_empty=1 and no pop was issued this cycle.
  - IDLE/ACTIVE with init=1: -> INIT; no pop is issued in that cycle.
  - Any fifo_error bit set in IDLE/ACTIVE/INIT: -> ERROR. Error takes priority over init.
  - ERROR: sticky until reset; no pops or pushes.
- Eligibility: elig[i] = (estado==ACTIVE) & ~vc_empty[i] & ~pause[i] & ~init & ~|fifo_error.
- Grant: first eligible VC scanning last+1, last+2, ... modulo 4. vc_pop = one-hot of the grant. On a grant, last <= granted index. With no grant, last is held.
- Latency:
  - Pop at cycle t registers data_out <= vc_data[g] and dst_push <= onehot(g) at t+1. dst_push is high for exactly one cycle per pop.
  - data_out holds its last value when no push is issued.
- Back-pressure with hysteresis, evaluated every cycle:
  - eff[i] = dst_count[i] + dst_push[i] (width UMBRALES_L_H+1, no wrap).
  - eff[i] >= umbral_H sets pause[i]. eff[i] <= umbral_L clears it. Between the two thresholds, pause[i] holds.
  - pause is cleared on entry to INIT.
- Simultaneous events: a single eligible VC is granted on consecutive cycles (full throughput). With four VCs eligible, grants run 0,1,2,3,0,...
- umbral_* are stable outside INIT.

Test Plan:
- Reset/defaults: reset=1 for 2 cycles -> estado=000, umbral_L=1, umbral_H=6, all vc_pop/dst_push=0. Then reset=0, init=0 -> estado=010 next cycle.
- Config: init=1 with umbral_L_in=2, umbral_H_in=5 for 3 cycles, then init=0 -> umbral_L=2, umbral_H=5, estado=010. Repeat with L=5, H=5 -> estado=100; error_out stays 1 until reset.
- Round robin: all vc_empty=0, dst_count=0, VC heads 12'h4A4, 12'h415, 12'h4A5, 12'hC8D -> vc_pop 0001, 0010, 0100, 1000, 0001 on consecutive cycles. data_out/dst_push follow one cycle later with the matching word.
- Back-pressure: umbral_H=6, umbral_L=1, only VC2 non-empty; dst_count[2] ramps 0..6 -> pops stop once eff>=6. They resume only after dst_count[2] falls to 1, with no resumption at 3.
- Mid-operation: fifo_error=0100 during ACTIVE -> no pop that cycle, estado=100. Separately, init=1 during ACTIVE -> estado=001, pause cleared. Separately, reset during a grant -> no dst_push the following cycle.
- Drain: single word in VC3 -> one pop, dst_push=1000 next cycle, then estado returns to 010.

Source files
------------

// File: rtl/arbitro_vc_pcie.sv
// Round-robin scheduler moving words from four source VC FIFOs to their matching destination FIFOs.
// Latency: a pop in cycle t shows up as data_out/dst_push in cycle t+1; one word per cycle at most.
// Backpressure: each destination pauses at or above umbral_H and resumes at or below umbral_L (hysteresis).
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   init                configuration request; thresholds are captured while high in INIT
//   umbral_L_in/_H_in   candidate low/high thresholds
//   vc_empty, vc_data   source FIFO empty flags and first-word-fall-through heads
//   dst_count           occupancy of each destination FIFO
//   fifo_error          overflow/underflow flags from every FIFO
//   vc_pop              one-hot source pop (combinational from registered state)
//   dst_push, data_out  registered one-hot destination push and shared data bus
//   umbral_L/_H         active thresholds
//   estado, idle, error_out  FSM state and decoded status
module arbitro_vc_pcie #(
    parameter int TAMANO_DATOS = 12,
    parameter int UMBRALES_L_H = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init,
    input  logic [UMBRALES_L_H-1:0]   umbral_L_in,
    input  logic [UMBRALES_L_H-1:0]   umbral_H_in,
    input  logic [3:0]                vc_empty,
    input  logic [4*TAMANO_DATOS-1:0] vc_data,
    input  logic [4*UMBRALES_L_H-1:0] dst_count,
    input  logic [3:0]                fifo_error,
    output logic [3:0]                vc_pop,
    output logic [3:0]                dst_push,
    output logic [TAMANO_DATOS-1:0]   data_out,
    output logic [UMBRALES_L_H-1:0]   umbral_L,
    output logic [UMBRALES_L_H-1:0]   umbral_H,
    output logic [2:0]                estado,
    output logic                      idle,
    output logic                      error_out
);

    // Occupancy plus an in-flight push needs one extra bit so it never wraps.
    localparam int EFF_W = UMBRALES_L_H + 1;

    typedef enum logic [2:0] {
        ST_RESET  = 3'b000,
        ST_INIT   = 3'b001,
        ST_IDLE   = 3'b010,
        ST_ACTIVE = 3'b011,
        ST_ERROR  = 3'b100
    } estado_t;

    estado_t                 estado_q,   estado_d;
    logic [UMBRALES_L_H-1:0] umbral_l_q, umbral_l_d;
    logic [UMBRALES_L_H-1:0] umbral_h_q, umbral_h_d;
    logic [3:0]              pause_q,    pause_d;
    logic [1:0]              last_q,     last_d;
    logic [3:0]              dst_push_q, dst_push_d;
    logic [TAMANO_DATOS-1:0] data_out_q, data_out_d;

    logic [TAMANO_DATOS-1:0] vc_head [4];
    logic [3:0]              elig;
    logic                    grant_vld;
    logic [1:0]              grant_idx;
    logic                    any_error;

    assign any_error = |fifo_error;

    // Unpack the concatenated FIFO heads so the granted word can be picked by index.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            vc_head[i] = vc_data[i*TAMANO_DATOS +: TAMANO_DATOS];
        end
    end

    // ------------------------------------------------------------------
    // Eligibility and round-robin grant
    // ------------------------------------------------------------------
    // A pending init or error request suppresses pops in the same cycle,
    // so no word is lost while the FSM leaves ACTIVE. Reset is folded in
    // so a word popped during reset can never be dropped on the floor.
    always_comb begin
        elig = 4'b0000;
        if (!reset && (estado_q == ST_ACTIVE) && !init && !any_error) begin
            elig = ~vc_empty & ~pause_q;
        end
    end

    // Scan from the farthest candidate (last+4) towards the nearest (last+1);
    // the nearest eligible one is written last and therefore wins.
    always_comb begin
        logic [1:0] cand;
        cand      = 2'd0;
        grant_vld = 1'b0;
        grant_idx = last_q;
        for (int k = 4; k >= 1; k--) begin
            cand = last_q + 2'(k);
            if (elig[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        vc_pop = 4'b0000;
        if (grant_vld) begin
            vc_pop = 4'b0001 << grant_idx;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            ST_RESET: begin
                estado_d = init ? ST_INIT : ST_IDLE;
            end
            ST_INIT: begin
                if (any_error) begin
                    estado_d = ST_ERROR;
                end else if (!init) begin
                    // Validate the thresholds that were captured while init was high.
                    estado_d = (umbral_l_q < umbral_h_q) ? ST_IDLE : ST_ERROR;
                end
            end
            ST_IDLE: begin
                if (any_error) begin
                    estado_d = ST_ERROR;
                end else if (init) begin
                    estado_d = ST_INIT;
                end else if (vc_empty != 4'b1111) begin
                    estado_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (any_error) begin
                    estado_d = ST_ERROR;
                end else if (init) begin
                    estado_d = ST_INIT;
                end else if ((vc_empty == 4'b1111) && !grant_vld) begin
                    estado_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                estado_d = ST_ERROR;
            end
            default: begin
                estado_d = ST_ERROR;
            end
        endcase
    end

    // Thresholds only move while the FSM sits in INIT with init held high.
    always_comb begin
        umbral_l_d = umbral_l_q;
        umbral_h_d = umbral_h_q;
        if ((estado_q == ST_INIT) && init) begin
            umbral_l_d = umbral_L_in;
            umbral_h_d = umbral_H_in;
        end
    end

    // ------------------------------------------------------------------
    // Per-destination pause with hysteresis
    // ------------------------------------------------------------------
    // The word pushed this cycle is not yet reflected in dst_count, so it is
    // added in to avoid overshooting the high threshold by one word.
    always_comb begin
        logic [EFF_W-1:0] eff;
        eff     = '0;
        pause_d = pause_q;
        for (int i = 0; i < 4; i++) begin
            eff = {1'b0, dst_count[i*UMBRALES_L_H +: UMBRALES_L_H]} + EFF_W'(dst_push_q[i]);
            if (eff >= {1'b0, umbral_h_q}) begin
                pause_d[i] = 1'b1;
            end else if (eff <= {1'b0, umbral_l_q}) begin
                pause_d[i] = 1'b0;
            end
        end
        // A reconfiguration starts every destination from a clean slate.
        if (estado_d == ST_INIT) begin
            pause_d = 4'b0000;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: one registered stage from pop to push
    // ------------------------------------------------------------------
    always_comb begin
        last_d     = last_q;
        dst_push_d = vc_pop;
        data_out_d = data_out_q;
        if (grant_vld) begin
            last_d     = grant_idx;
            data_out_d = vc_head[grant_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= ST_RESET;
            umbral_l_q <= UMBRALES_L_H'(1);
            umbral_h_q <= UMBRALES_L_H'(6);
            pause_q    <= 4'b0000;
            last_q     <= 2'd3;
            dst_push_q <= 4'b0000;
            data_out_q <= '0;
        end else begin
            estado_q   <= estado_d;
            umbral_l_q <= umbral_l_d;
            umbral_h_q <= umbral_h_d;
            pause_q    <= pause_d;
            last_q     <= last_d;
            dst_push_q <= dst_push_d;
            data_out_q <= data_out_d;
        end
    end

    assign estado    = estado_q;
    assign idle      = (estado_q == ST_IDLE);
    assign error_out = (estado_q == ST_ERROR);
    assign dst_push  = dst_push_q;
    assign data_out  = data_out_q;
    assign umbral_L  = umbral_l_q;
    assign umbral_H  = umbral_h_q;

endmodule
